// File: rtl/mem_pkg.sv
// Shared types and constants for the data/instruction memory responders.
// Holds the responder FSM encoding and word-alignment helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_DONE
  } mem_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [31:0] a);
    return (a[1:0] & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter producing the wait-state expiry for memory responders.
// expire_o is high while the count sits at 1, i.e. the last wait cycle.
module mem_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with ReqM/ReadyM handshake and wait states.
// Misaligned requests complete immediately with AlignErr and touch no RAM.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqM,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ReadyM,
  output logic        StallM,
  output logic        AlignErr
);

  localparam int         AW  = $clog2(DEPTH);
  localparam int         OFS = $clog2(WORD_BYTES);
  localparam logic [3:0] WS  = 4'(WAIT_STATES);

  mem_state_t state_q, state_d;

  logic          we_q;
  logic [31:0]   wd_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   ram_q [DEPTH];

  logic          accept;
  logic          expire;
  logic          done_d;
  logic          acc_we;
  logic          acc_mis;
  logic [31:0]   acc_wd;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rdata_d;
  logic          err_d;
  logic          unused_adr;

  assign unused_adr = ^DataAdr[31:AW+OFS];
  assign accept     = (state_q == MEM_IDLE) & ReqM;

  // On the accepting edge the latch is not loaded yet, so use the live bus.
  assign acc_we  = accept ? MemWriteM : we_q;
  assign acc_wd  = accept ? WriteData : wd_q;
  assign acc_idx = accept ? DataAdr[AW+OFS-1:OFS] : idx_q;
  assign acc_mis = accept & misaligned(DataAdr);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (ReqM) begin
          if (WS == 4'd0 || acc_mis) begin
            state_d = MEM_DONE;
          end else begin
            state_d = MEM_BUSY;
          end
        end
      end
      MEM_BUSY: begin
        if (expire) begin
          state_d = MEM_DONE;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
    done_d = (state_d == MEM_DONE);
    if (done_d) begin
      if (acc_mis) begin
        err_d = 1'b1;
      end else if (!acc_we) begin
        rdata_d = ram_q[acc_idx];
      end
    end
  end

  mem_wait_timer #(
    .W(4)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (accept),
    .value_i (WS),
    .expire_o(expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= MEM_IDLE;
      we_q     <= 1'b0;
      wd_q     <= '0;
      idx_q    <= '0;
      ReadyM   <= 1'b0;
      ReadData <= '0;
      AlignErr <= 1'b0;
    end else begin
      state_q  <= state_d;
      ReadyM   <= done_d;
      ReadData <= rdata_d;
      AlignErr <= err_d;
      if (accept) begin
        we_q  <= MemWriteM;
        wd_q  <= WriteData;
        idx_q <= DataAdr[AW+OFS-1:OFS];
      end
    end
  end

  // RAM keeps its contents across reset; a reset edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && done_d && acc_we && !acc_mis) begin
      ram_q[acc_idx] <= acc_wd;
    end
  end

  assign StallM = ReqM & ~ReadyM;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one WAIT_STATES=2 and one =0 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] adr   [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        rdy   [2];
  logic        stall [2];
  logic        err   [2];

  int ws [2] = '{2, 0};
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .reset(rst_n), .ReqM(req[0]), .MemWriteM(we[0]),
    .DataAdr(adr[0]), .WriteData(wd[0]), .ReadData(rd[0]),
    .ReadyM(rdy[0]), .StallM(stall[0]), .AlignErr(err[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(rst_n), .ReqM(req[1]), .MemWriteM(we[1]),
    .DataAdr(adr[1]), .WriteData(wd[1]), .ReadData(rd[1]),
    .ReadyM(rdy[1]), .StallM(stall[1]), .AlignErr(err[1])
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          chk;
  } exp_t;

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [31:0] data;
    logic [31:0] rd;
    bit          chk;
  } vec_t;

  exp_t sb [$];
  vec_t tbl [13];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one request, hold ReqM until ReadyM, then drop it.
  // scr=1 perturbs the bus right after acceptance.
  task automatic txn(int d, bit w, logic [31:0] a, logic [31:0] data,
                     logic [31:0] exp_rd, bit chk, bit scr);
    exp_t e;
    int   lat;
    bit   got;
    bit   mis;
    got   = 1'b0;
    mis   = (a[1:0] != 2'b00);
    lat   = mis ? 1 : ws[d] + 1;
    e.rd  = (mis || w) ? 32'h0 : exp_rd;
    e.err = mis;
    e.chk = chk || w || mis;
    sb.push_back(e);
    req[d] = 1'b1;
    we[d]  = w;
    adr[d] = a;
    wd[d]  = data;
    for (int n = 1; n <= 20 && !got; n++) begin
      tick();
      if (scr && n == 1) begin
        adr[d] = a ^ 32'h4;
        wd[d]  = ~data;
        we[d]  = ~w;
      end
      if (rdy[d]) begin
        got = 1'b1;
        e   = sb.pop_front();
        check("latency", n, lat);
        check("stall_done", 32'(stall[d]), 32'h0);
        check("align_err", 32'(err[d]), 32'(e.err));
        if (e.chk) check("rdata", rd[d], e.rd);
      end else begin
        check("stall_wait", 32'(stall[d]), 32'h1);
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got no ReadyM want pulse (dut %0d adr %h)", d, a);
      void'(sb.pop_front());
    end
    req[d] = 1'b0;
    we[d]  = 1'b0;
    tick();
    check("idle_ready", 32'(rdy[d]), 32'h0);
    check("idle_rdata", rd[d], 32'h0);
    check("idle_err", 32'(err[d]), 32'h0);
    check("idle_stall", 32'(stall[d]), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    tbl[0]  = '{0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        1'b1};
    tbl[1]  = '{0, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1};
    tbl[2]  = '{0, 1'b1, 32'h013, 32'h12345678, 32'h0,        1'b1};
    tbl[3]  = '{0, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1};
    tbl[4]  = '{0, 1'b1, 32'h100, 32'h00000055, 32'h0,        1'b1};
    tbl[5]  = '{0, 1'b0, 32'h000, 32'h0,        32'h00000055, 1'b1};
    tbl[6]  = '{0, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1};
    tbl[7]  = '{0, 1'b1, 32'h044, 32'h33333333, 32'h0,        1'b1};
    tbl[8]  = '{1, 1'b0, 32'h024, 32'h0,        32'h0,        1'b0};
    tbl[9]  = '{1, 1'b1, 32'h024, 32'hA5A50001, 32'h0,        1'b1};
    tbl[10] = '{1, 1'b0, 32'h124, 32'h0,        32'hA5A50001, 1'b1};
    tbl[11] = '{1, 1'b1, 32'h008, 32'hCAFEF00D, 32'h0,        1'b1};
    tbl[12] = '{1, 1'b0, 32'h008, 32'h0,        32'hCAFEF00D, 1'b1};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0;
      we[d]  = 1'b0;
      adr[d] = '0;
      wd[d]  = '0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(rdy[d]), 32'h0);
      check("rst_rdata", rd[d], 32'h0);
      check("rst_err", 32'(err[d]), 32'h0);
      check("rst_stall", 32'(stall[d]), 32'h0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].data, tbl[i].rd, tbl[i].chk, 1'b0);
    end

    // Bus changes during BUSY must not affect the latched request.
    txn(0, 1'b1, 32'h040, 32'h11111111, 32'h0, 1'b1, 1'b1);
    txn(0, 1'b0, 32'h040, 32'h0, 32'h11111111, 1'b1, 1'b1);
    txn(0, 1'b0, 32'h044, 32'h0, 32'h33333333, 1'b1, 1'b0);

    // Reset lands on the edge that would complete a write.
    req[0] = 1'b1;
    we[0]  = 1'b1;
    adr[0] = 32'h010;
    wd[0]  = 32'hBAD0BAD0;
    tick();
    tick();
    check("busy_stall", 32'(stall[0]), 32'h1);
    rst_n  = 1'b0;
    req[0] = 1'b0;
    we[0]  = 1'b0;
    tick();
    check("abort_ready", 32'(rdy[0]), 32'h0);
    check("abort_rdata", rd[0], 32'h0);
    check("abort_err", 32'(err[0]), 32'h0);
    check("abort_stall", 32'(stall[0]), 32'h0);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (rdy[0]) seen = 1'b1;
    end
    check("abort_no_ready", 32'(seen), 32'h0);
    txn(0, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);

    // Back-to-back reads with ReqM held: DONE must not re-accept.
    req[1] = 1'b1;
    we[1]  = 1'b0;
    adr[1] = 32'h008;
    for (int n = 1; n <= 5; n++) begin
      tick();
      check("b2b_ready", 32'(rdy[1]), (n == 1 || n == 3) ? 32'h1 : 32'h0);
      check("b2b_rdata", rd[1], (n == 1 || n == 3) ? 32'hCAFEF00D : 32'h0);
      if (n == 3) req[1] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
